imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//   Write-side counterpart to the instruction-memory fetch path. Receives a byte stream,
//   assembles big-endian 32-bit MIPS instruction words and writes them to consecutive
//   word addresses of instruction memory. Holds the CPU (cpu_hold) until the image is loaded.
// PARAMETERS
//   ADDR_WIDTH  8   word-address width; DEPTH = 1<<ADDR_WIDTH words
//   BASE_ADDR   0   byte address of the first word written (word aligned)
// PORTS
//   clk          in   1             clock; all state updates on the rising edge
//   reset        in   1             asynchronous, active-high reset
//   start        in   1             pulse: begin a load; sampled in IDLE and DONE only
//   len          in   ADDR_WIDTH+1  number of words to load; sampled with start
//   in_data      in   8             stream byte
//   in_valid     in   1             in_data valid
//   in_ready     out  1             loader accepts byte; transfer = in_valid & in_ready at the edge
//   mem_we       out  1             one-cycle instruction-memory write strobe
//   mem_addr     out  32            byte address = BASE_ADDR + 4*word_index
//   mem_wdata    out  32            assembled instruction word
//   cpu_hold     out  1             1 = CPU held in reset / PC frozen
//   done         out  1             load finished (success or error)
//   error        out  1             length or checksum error on last load
//   word_count   out  ADDR_WIDTH+1  words written in current/last load
// BEHAVIOUR
//   - Reset values: in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=1,
//     done=0, error=0, word_count=0, state=IDLE, byte counter=0.
//   - FSM: IDLE -start-> RECV (len>0 and len<=DEPTH) | DONE (len==0, error=0)
//     | DONE (len>DEPTH, error=1, no writes). RECV -4th byte accepted-> WRITE.
//     WRITE (1 cycle) -> RECV if word_count+1<len, else CHK (CHECKSUM_EN) or DONE.
//     DONE -start-> same decision as IDLE; cpu_hold reasserts, done/error/word_count clear.
//   - in_ready=1 only in RECV (and CHK); 0 in IDLE, WRITE, DONE: one bubble per word.
//   - Byte order big-endian: 1st byte -> mem_wdata[31:24], 4th -> [7:0].
//   - In WRITE: mem_we=1 for exactly one cycle with mem_addr/mem_wdata stable;
//     word_count increments at the end of that cycle; mem_addr advances by 4 after.
//   - in_valid low stalls without losing partial word; no timeout.
//   - start while in RECV/WRITE/CHK ignored; len only sampled at accepted start.
//   - cpu_hold=0 only in DONE with error=0; with error=1 CPU stays held.
//   - done=1 only in DONE. Address never exceeds BASE_ADDR+4*(DEPTH-1).
//   - Reset mid-load: immediate return to reset values; partial word discarded; words
//     already written remain in memory (not rolled back).
// CONFIGURATION
//   IMEM_LOADER_CHECKSUM_EN defined: after the last word, state CHK accepts one extra byte;
//     error=1 if it differs from XOR of all data bytes of the load; then DONE.
//     len==0: checksum byte still expected, reference value 0x00.
//   Not defined: no CHK state, no checksum byte; error set only by len>DEPTH.
// TESTING
//   1. Assert reset -> cpu_hold=1, done=0, in_ready=0, mem_we=0, word_count=0, async (no clk edge).
//   2. start, len=2, bytes 20 08 00 05 8C 09 00 04 -> writes 0x20080005@0x0, 0x8C090004@0x4,
//      one mem_we pulse each; done=1, cpu_hold=0, word_count=2, error=0.
//   3. start len=0 -> done=1, no mem_we; start len=DEPTH+1 -> done=1, error=1, cpu_hold=1, no mem_we.
//   4. Test 2 with in_valid toggled every other cycle -> identical writes and final state.
//   5. Test 2, reset after 6th byte -> reset values; exactly one write (0x20080005@0x0) seen.
//   6. CHECKSUM_EN: test 2 + byte 0xAC -> error=0, cpu_hold=0; + 0xAD -> error=1, cpu_hold=1.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream loader: packs big-endian bytes into 32-bit words, writes them to consecutive imem words, holds the CPU until done.
// Optional checksum byte after the image when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  input  logic [7:0]            in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic                  mem_we_o,
  output logic [31:0]           mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic                  cpu_hold_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [ADDR_WIDTH:0]   word_count_o
);

  localparam int                DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           addr_q, addr_d;
  logic [ADDR_WIDTH:0]   wc_q, wc_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic                  err_q, err_d;
  logic                  accept;
  logic                  more_words;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  assign accept     = in_valid_i & in_ready_o;
  assign more_words = ({1'b0, wc_q} + (ADDR_WIDTH+2)'(1)) < {1'b0, len_q};

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    wdata_d    = wdata_q;
    addr_d     = addr_q;
    wc_d       = wc_q;
    len_d      = len_q;
    err_d      = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          wc_d       = '0;
          err_d      = 1'b0;
          addr_d     = BASE_ADDR;
          byte_cnt_d = 2'd0;
          len_d      = len_i;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = 8'h00;
`endif
          if (len_i == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
`endif
          end else if (len_i > DEPTH_L) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = S_RECV;
          end
        end
      end
      S_RECV: begin
        if (accept) begin
          wdata_d    = {wdata_q[23:0], in_data_i};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ in_data_i;
`endif
          if (byte_cnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        wc_d = wc_q + (ADDR_WIDTH+1)'(1);
        // Address only advances when another word follows, so it never runs past the last word.
        if (more_words) begin
          state_d = S_RECV;
          addr_d  = addr_q + 32'd4;
        end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          err_d   = (in_data_i != csum_q);
          state_d = S_DONE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 2'd0;
      wdata_q    <= 32'h0;
      addr_q     <= BASE_ADDR;
      wc_q       <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      wdata_q    <= wdata_d;
      addr_q     <= addr_d;
      wc_q       <= wc_d;
      len_q      <= len_d;
      err_q      <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign in_ready_o = (state_q == S_RECV) || (state_q == S_CHK);
`else
  assign in_ready_o = (state_q == S_RECV);
`endif
  assign mem_we_o     = (state_q == S_WRITE);
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign done_o       = (state_q == S_DONE);
  assign error_o      = err_q;
  assign cpu_hold_o   = !((state_q == S_DONE) && !err_q);
  assign word_count_o = wc_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: vector table of loads plus hand sequences for async and mid-load reset.
module tb_imem_loader;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   len;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready, mem_we, cpu_hold, done, error;
  logic [31:0]   mem_addr, mem_wdata;
  logic [AW:0]   word_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(32'h0)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .len_i(len),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .cpu_hold_o(cpu_hold), .done_o(done), .error_o(error), .word_count_o(word_count)
  );

  // Write strobe is high for whole cycles, so one negedge sample per written word.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
  end

  typedef struct packed {
    logic [AW:0]  len;
    logic [3:0]   nbytes;
    logic [95:0]  b;
    logic [1:0]   nw;
    logic [95:0]  w;
    logic         tog;
    logic [7:0]   csum;
    logic         err;
    logic         hold;
    logic [AW:0]  wc;
  } vec_t;

  function automatic vec_t mk(input logic [AW:0] l, input logic [3:0] nb, input logic [95:0] b,
                              input logic [1:0] nw, input logic [95:0] w, input logic tog,
                              input logic [7:0] cs, input logic e, input logic h, input logic [AW:0] wc);
    vec_t v;
    v.len = l; v.nbytes = nb; v.b = b; v.nw = nw; v.w = w; v.tog = tog;
    v.csum = cs; v.err = e; v.hold = h; v.wc = wc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [AW:0] l);
    start = 1'b1;
    len   = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // tog: one idle cycle before each byte; poke: pulse start (len=0) during that idle cycle.
  task automatic send_byte(input logic [7:0] b, input logic tog, input logic poke);
    int guard;
    bit got;
    guard = 0;
    got   = 1'b0;
    if (tog) begin
      in_valid = 1'b0;
      if (poke) begin start = 1'b1; len = '0; end
      @(posedge clk); #1;
      start = 1'b0;
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!got) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      @(posedge clk); #1;
      guard++;
      if (!got && guard > 50) begin
        n_tests++;
        n_fail++;
        $display("FAIL byte_timeout: byte %h never accepted", b);
        got = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int g;
    g = 0;
    while (!done && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    check({name, "_done"}, {31'b0, done}, 32'd1);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_hold"},  {31'b0, cpu_hold}, 32'd1);
    check({name, "_done"},  {31'b0, done},     32'd0);
    check({name, "_rdy"},   {31'b0, in_ready}, 32'd0);
    check({name, "_we"},    {31'b0, mem_we},   32'd0);
    check({name, "_err"},   {31'b0, error},    32'd0);
    check({name, "_wc"},    32'(word_count),   32'd0);
    check({name, "_addr"},  mem_addr,          32'h0);
    check({name, "_wdata"}, mem_wdata,         32'h0);
  endtask

  vec_t vecs[6];

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    len      = '0;
    in_data  = 8'h00;
    in_valid = 1'b0;

    vecs[0] = mk(9'd2,   4'd8,  96'h20080005_8C090004_00000000, 2'd2,
                 96'h20080005_8C090004_00000000, 1'b0, 8'hAC, 1'b0, 1'b0, 9'd2);
    vecs[1] = mk(9'd0,   4'd0,  96'h0, 2'd0, 96'h0, 1'b0, 8'h00, 1'b0, 1'b0, 9'd0);
    vecs[2] = mk(9'd257, 4'd0,  96'h0, 2'd0, 96'h0, 1'b0, 8'h00, 1'b1, 1'b1, 9'd0);
    vecs[3] = mk(9'd2,   4'd8,  96'h20080005_8C090004_00000000, 2'd2,
                 96'h20080005_8C090004_00000000, 1'b1, 8'hAC, 1'b0, 1'b0, 9'd2);
    vecs[4] = mk(9'd3,   4'd12, 96'h01020304_FFEEDDCC_00000000, 2'd3,
                 96'h01020304_FFEEDDCC_00000000, 1'b0, 8'h04, 1'b0, 1'b0, 9'd3);
    vecs[5] = mk(9'd1,   4'd4,  96'hDEADBEEF_00000000_00000000, 2'd1,
                 96'hDEADBEEF_00000000_00000000, 1'b1, 8'h22, 1'b0, 1'b0, 9'd1);

    #3;
    check_reset_vals("rst0");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      vec_t v;
      string nm;
      v  = vecs[i];
      nm = $sformatf("v%0d", i);
      wr_addr.delete();
      wr_data.delete();
      do_start(v.len);
      if (v.len != '0 && v.len <= 9'(DEPTH)) begin
        check({nm, "_hold_restart"}, {31'b0, cpu_hold}, 32'd1);
        check({nm, "_done_restart"}, {31'b0, done},     32'd0);
      end
      for (int k = 0; k < 12; k++)
        if (k < int'(v.nbytes)) send_byte(v.b[95-8*k -: 8], v.tog, v.tog);
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (v.len <= 9'(DEPTH)) send_byte(v.csum, 1'b0, 1'b0);
`endif
      wait_done(nm);
      check({nm, "_err"},  {31'b0, error},    {31'b0, v.err});
      check({nm, "_hold"}, {31'b0, cpu_hold}, {31'b0, v.hold});
      check({nm, "_wc"},   32'(word_count),   32'(v.wc));
      check({nm, "_nwr"},  32'(wr_addr.size()), 32'(v.nw));
      check({nm, "_addr_final"}, mem_addr, (v.nw != 0) ? 32'(4 * (int'(v.nw) - 1)) : 32'h0);
      for (int k = 0; k < 3; k++) begin
        if (k < int'(v.nw) && k < wr_addr.size()) begin
          check($sformatf("%s_waddr%0d", nm, k), wr_addr[k], 32'(4 * k));
          check($sformatf("%s_wdata%0d", nm, k), wr_data[k], v.w[95-32*k -: 32]);
        end
      end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    wr_addr.delete();
    wr_data.delete();
    do_start(9'd2);
    for (int k = 0; k < 8; k++) send_byte(vecs[0].b[95-8*k -: 8], 1'b0, 1'b0);
    send_byte(8'hAD, 1'b0, 1'b0);
    wait_done("badcs");
    check("badcs_err",  {31'b0, error},    32'd1);
    check("badcs_hold", {31'b0, cpu_hold}, 32'd1);
    check("badcs_nwr",  32'(wr_addr.size()), 32'd2);
`endif

    // Reset after the 6th byte: first word already written, partial second word dropped.
    wr_addr.delete();
    wr_data.delete();
    do_start(9'd2);
    for (int k = 0; k < 6; k++) send_byte(vecs[0].b[95-8*k -: 8], 1'b0, 1'b0);
    reset = 1'b1;
    #2;
    check_reset_vals("midrst");
    check("midrst_nwr", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() > 0) begin
      check("midrst_waddr", wr_addr[0], 32'h0);
      check("midrst_wdata", wr_data[0], 32'h20080005);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
